tinyalu_cmd_driver: RTL

- Synthesizable, parametrised command driver for a TinyALU-class ALU.
- Replaces testbench-only op sequencing with a queued valid/ready command port, a DEPTH-entry command FIFO and an FSM.
- The FSM drives the ALU start/op/operand/reset pins, waits for done (with timeout) and returns a result/status response.
- Sits between a command source (stimulus or CPU-side logic) and the ALU; one command in flight at a time.

---
 rtl/tinyalu_cmd_driver_if.sv | 26 ++
 rtl/tinyalu_cmd_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_cmd_driver_if.sv
// Command/response bundle between a command source and tinyalu_cmd_driver.
// The master side offers commands and consumes responses; the slave side is the driver.
interface tinyalu_cmd_driver_if #(
    parameter int unsigned DATA_W = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [2:0]          cmd_op;
    logic [DATA_W-1:0]   cmd_a;
    logic [DATA_W-1:0]   cmd_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [2:0]          rsp_op;
    logic [2*DATA_W-1:0] rsp_result;
    logic [1:0]          rsp_status;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_op, rsp_result, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_op, rsp_result, rsp_status
    );
endinterface

// File: rtl/tinyalu_cmd_driver.sv
// Queued command driver for a TinyALU-class ALU: buffers commands in a small FIFO and
// sequences one ALU operation at a time, returning result and status as a response.
module tinyalu_cmd_driver #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    tinyalu_cmd_driver_if.slave   bus,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [2:0]            alu_op,
    output logic                  alu_start,
    output logic                  alu_reset_n,
    input  logic                  alu_done,
    input  logic [2*DATA_W-1:0]   alu_result,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
    localparam int unsigned RcW  = $clog2(RST_CYCLES + 1);

    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [TmrW-1:0] TmrLast  = TmrW'(TIMEOUT - 1);
    localparam logic [RcW-1:0]  RcLast   = RcW'(RST_CYCLES - 1);

    localparam logic [2:0] OpNoOp = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpAnd  = 3'b010;
    localparam logic [2:0] OpXor  = 3'b011;
    localparam logic [2:0] OpMul  = 3'b100;
    localparam logic [2:0] OpRst  = 3'b111;

    localparam logic [1:0] StatOk      = 2'b00;
    localparam logic [1:0] StatIllegal = 2'b01;
    localparam logic [1:0] StatTimeout = 2'b10;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StRun, StAluRst, StResp} state_e;

    // ---------------------------------------------------------------- FIFO
    cmd_t            mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q;
    logic            push, pop;
    cmd_t            head;

    assign push = bus.cmd_valid && !full_q;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DepthCnt);
        end
    end

    // ---------------------------------------------------------------- FSM
    state_e                state_q, state_d;
    logic [DATA_W-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]            alu_op_q, alu_op_d;
    logic                  alu_start_q, alu_start_d;
    logic                  alu_reset_n_q, alu_reset_n_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [2:0]            rsp_op_q, rsp_op_d;
    logic [2*DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic [1:0]            rsp_status_q, rsp_status_d;
    logic [TmrW-1:0]       timer_q, timer_d;
    logic [RcW-1:0]        rst_cnt_q, rst_cnt_d;

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        alu_start_d   = alu_start_q;
        alu_reset_n_d = 1'b1;
        rsp_valid_d   = rsp_valid_q;
        rsp_op_d      = rsp_op_q;
        rsp_result_d  = rsp_result_q;
        rsp_status_d  = rsp_status_q;
        timer_d       = timer_q;
        rst_cnt_d     = rst_cnt_q;
        pop           = 1'b0;

        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop          = 1'b1;
                    alu_a_d      = head.a;
                    alu_b_d      = head.b;
                    alu_op_d     = head.op;
                    rsp_op_d     = head.op;
                    rsp_result_d = '0;
                    rsp_status_d = StatOk;
                    unique case (head.op)
                        OpNoOp, OpAdd, OpAnd, OpXor, OpMul: begin
                            alu_start_d = 1'b1;
                            timer_d     = '0;
                            state_d     = StRun;
                        end
                        OpRst: begin
                            alu_reset_n_d = 1'b0;
                            rst_cnt_d     = '0;
                            state_d       = StAluRst;
                        end
                        default: begin
                            rsp_status_d = StatIllegal;
                            rsp_valid_d  = 1'b1;
                            state_d      = StResp;
                        end
                    endcase
                end
            end
            StRun: begin
                // no_op: one start cycle, then one settling cycle before responding
                if (alu_op_q == OpNoOp) begin
                    if (alu_start_q) begin
                        alu_start_d = 1'b0;
                    end else begin
                        rsp_valid_d = 1'b1;
                        state_d     = StResp;
                    end
                end else if (alu_done) begin
                    alu_start_d  = 1'b0;
                    rsp_result_d = alu_result;
                    rsp_valid_d  = 1'b1;
                    state_d      = StResp;
                end else if (timer_q == TmrLast) begin
                    alu_start_d   = 1'b0;
                    rsp_status_d  = StatTimeout;
                    rsp_result_d  = '0;
                    alu_reset_n_d = 1'b0;
                    rst_cnt_d     = '0;
                    state_d       = StAluRst;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StAluRst: begin
                if (rst_cnt_q == RcLast) begin
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    alu_reset_n_d = 1'b0;
                    rst_cnt_d     = rst_cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            alu_start_q   <= 1'b0;
            alu_reset_n_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_op_q      <= '0;
            rsp_result_q  <= '0;
            rsp_status_q  <= '0;
            timer_q       <= '0;
            rst_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            alu_start_q   <= alu_start_d;
            alu_reset_n_q <= alu_reset_n_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_op_q      <= rsp_op_d;
            rsp_result_q  <= rsp_result_d;
            rsp_status_q  <= rsp_status_d;
            timer_q       <= timer_d;
            rst_cnt_q     <= rst_cnt_d;
        end
    end

    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_op         = alu_op_q;
    assign alu_start      = alu_start_q;
    assign alu_reset_n    = alu_reset_n_q;
    assign fifo_count     = count_q;
    assign bus.cmd_ready  = !full_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_status = rsp_status_q;

endmodule
